// File: rtl/obj_affine_tile_fetch.sv
// OBJ affine texel fetch: maps an in-object texel coordinate to an OBJ VRAM halfword,
// extracts the palette index and writes it into the OBJ line buffer at the pixel's column.
module obj_affine_tile_fetch #(
  parameter int VRAM_AW = 15,
  parameter int LB_AW   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [5:0]         pix_x,
  input  logic [5:0]         pix_y,
  input  logic               pix_transp,
  input  logic [LB_AW-1:0]   pix_col,
  input  logic [9:0]         tile_base,
  input  logic               color_8bpp,
  input  logic [3:0]         pal_bank,
  input  logic               map_1d,
  input  logic [6:0]         hsize,
  input  logic               line_abort,
  output logic               vram_req,
  output logic [VRAM_AW-2:0] vram_addr,
  input  logic               vram_gnt,
  input  logic               vram_rvalid,
  input  logic [15:0]        vram_rdata,
  output logic               lb_we,
  output logic [LB_AW-1:0]   lb_addr,
  output logic [7:0]         lb_data
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_WRITE, S_DRAIN} state_t;

  state_t             state_q, state_d;
  logic               vram_req_q, vram_req_d;
  logic [VRAM_AW-2:0] vram_addr_q, vram_addr_d;
  logic               byte0_q, byte0_d;
  logic               px0_q, px0_d;
  logic               c8_q, c8_d;
  logic [3:0]         bank_q, bank_d;
  logic [LB_AW-1:0]   col_q, col_d;
  logic               lb_we_q, lb_we_d;
  logic [LB_AW-1:0]   lb_addr_q, lb_addr_d;
  logic [7:0]         lb_data_q, lb_data_d;

  logic [2:0]         tx, ty, px, py;
  logic [6:0]         stride;
  logic [9:0]         tile;
  logic [5:0]         row_off, col_off;
  logic [VRAM_AW-1:0] byte_addr;
  logic [7:0]         sel_byte;
  logic [3:0]         sel_nib;
  logic               idx_nz;
  logic               accept;

  // Texel byte address; tile number wraps at 1024, byte address at the VRAM size.
  always_comb begin
    tx        = pix_x[5:3];
    px        = pix_x[2:0];
    ty        = pix_y[5:3];
    py        = pix_y[2:0];
    stride    = map_1d ? ((hsize >> 3) << color_8bpp) : 7'd32;
    tile      = tile_base + (10'(ty) * 10'(stride)) + (10'(tx) << color_8bpp);
    row_off   = color_8bpp ? {py, 3'b000} : {1'b0, py, 2'b00};
    col_off   = color_8bpp ? {3'b000, px} : {4'b0000, px[2:1]};
    byte_addr = VRAM_AW'({tile, 5'b00000}) + VRAM_AW'(row_off) + VRAM_AW'(col_off);
  end

  always_comb begin
    sel_byte = byte0_q ? vram_rdata[15:8] : vram_rdata[7:0];
    sel_nib  = px0_q ? sel_byte[7:4] : sel_byte[3:0];
    idx_nz   = c8_q ? (sel_byte != 8'd0) : (sel_nib != 4'd0);
  end

  assign accept = pix_valid && (state_q == S_IDLE) && !line_abort;

  always_comb begin
    state_d     = state_q;
    vram_req_d  = vram_req_q;
    vram_addr_d = vram_addr_q;
    byte0_d     = byte0_q;
    px0_d       = px0_q;
    c8_d        = c8_q;
    bank_d      = bank_q;
    col_d       = col_q;
    lb_we_d     = 1'b0;
    lb_addr_d   = lb_addr_q;
    lb_data_d   = lb_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept && !pix_transp) begin
          state_d     = S_REQ;
          vram_req_d  = 1'b1;
          vram_addr_d = byte_addr[VRAM_AW-1:1];
          byte0_d     = byte_addr[0];
          px0_d       = pix_x[0];
          c8_d        = color_8bpp;
          bank_d      = pal_bank;
          col_d       = pix_col;
        end
      end
      S_REQ: begin
        if (vram_gnt) begin
          state_d    = S_WAIT;
          vram_req_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (vram_rvalid) begin
          state_d   = S_WRITE;
          lb_we_d   = idx_nz;
          lb_addr_d = col_q;
          lb_data_d = c8_q ? sel_byte : {bank_q, sel_nib};
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_DRAIN: begin
        if (vram_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A granted read still owes us data, so WAIT must drain it before reuse.
    if (line_abort) begin
      state_d    = (state_q == S_WAIT || state_q == S_DRAIN) ? S_DRAIN : S_IDLE;
      vram_req_d = 1'b0;
      lb_we_d    = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      vram_req_q  <= 1'b0;
      vram_addr_q <= '0;
      byte0_q     <= 1'b0;
      px0_q       <= 1'b0;
      c8_q        <= 1'b0;
      bank_q      <= 4'd0;
      col_q       <= '0;
      lb_we_q     <= 1'b0;
      lb_addr_q   <= '0;
      lb_data_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      vram_req_q  <= vram_req_d;
      vram_addr_q <= vram_addr_d;
      byte0_q     <= byte0_d;
      px0_q       <= px0_d;
      c8_q        <= c8_d;
      bank_q      <= bank_d;
      col_q       <= col_d;
      lb_we_q     <= lb_we_d;
      lb_addr_q   <= lb_addr_d;
      lb_data_q   <= lb_data_d;
    end
  end

  assign pix_ready = (state_q == S_IDLE);
  assign vram_req  = vram_req_q;
  assign vram_addr = vram_addr_q;
  assign lb_we     = lb_we_q;
  assign lb_addr   = lb_addr_q;
  assign lb_data   = lb_data_q;

endmodule

// File: tb/tb_obj_affine_tile_fetch.sv
// Bench for obj_affine_tile_fetch: directed vector table, multi-cycle corner sequences
// and randomized pixels checked against an arithmetic address/index model.
module tb_obj_affine_tile_fetch;

  logic        clock;
  logic        reset;
  logic        pix_valid;
  logic        pix_ready;
  logic [5:0]  pix_x;
  logic [5:0]  pix_y;
  logic        pix_transp;
  logic [7:0]  pix_col;
  logic [9:0]  tile_base;
  logic        color_8bpp;
  logic [3:0]  pal_bank;
  logic        map_1d;
  logic [6:0]  hsize;
  logic        line_abort;
  logic        vram_req;
  logic [13:0] vram_addr;
  logic        vram_gnt;
  logic        vram_rvalid;
  logic [15:0] vram_rdata;
  logic        lb_we;
  logic [7:0]  lb_addr;
  logic [7:0]  lb_data;

  int checks = 0;
  int errors = 0;

  obj_affine_tile_fetch #(.VRAM_AW(15), .LB_AW(8)) dut (
    .clock(clock), .reset(reset),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_transp(pix_transp), .pix_col(pix_col),
    .tile_base(tile_base), .color_8bpp(color_8bpp), .pal_bank(pal_bank),
    .map_1d(map_1d), .hsize(hsize), .line_abort(line_abort),
    .vram_req(vram_req), .vram_addr(vram_addr), .vram_gnt(vram_gnt),
    .vram_rvalid(vram_rvalid), .vram_rdata(vram_rdata),
    .lb_we(lb_we), .lb_addr(lb_addr), .lb_data(lb_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [5:0]  x;
    logic [5:0]  y;
    logic [9:0]  base;
    logic        c8;
    logic [3:0]  bank;
    logic        m1d;
    logic [6:0]  hs;
    logic [7:0]  col;
    logic [15:0] rdata;
    logic [13:0] exp_addr;
    logic        exp_we;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: texel byte address from coordinate arithmetic.
  function automatic int model_byte(input int x, input int y, input int base, input int c8,
                                    input int m1d, input int hs);
    int m, stride, tile;
    m      = c8 ? 2 : 1;
    stride = m1d ? (hs / 8) * m : 32;
    tile   = (base + (y / 8) * stride + (x / 8) * m) % 1024;
    return (tile * 32 + (y % 8) * (c8 ? 8 : 4) + (c8 ? (x % 8) : (x % 8) / 2)) % 32768;
  endfunction

  function automatic vec_t model_vec(input vec_t v);
    vec_t r;
    int b, bsel, n;
    r    = v;
    b    = model_byte(v.x, v.y, v.base, v.c8, v.m1d, v.hs);
    bsel = (b % 2 == 1) ? (v.rdata / 256) : (v.rdata % 256);
    r.exp_addr = 14'(b / 2);
    if (v.c8) begin
      r.exp_we   = (bsel != 0);
      r.exp_data = 8'(bsel);
    end else begin
      n = (v.x % 2 == 1) ? (bsel / 16) : (bsel % 16);
      r.exp_we   = (n != 0);
      r.exp_data = 8'(v.bank * 16 + n);
    end
    return r;
  endfunction

  task automatic drive_pixel(input vec_t v);
    pix_valid  = 1'b1;
    pix_transp = 1'b0;
    pix_x      = v.x;
    pix_y      = v.y;
    tile_base  = v.base;
    color_8bpp = v.c8;
    pal_bank   = v.bank;
    map_1d     = v.m1d;
    hsize      = v.hs;
    pix_col    = v.col;
  endtask

  // Scramble fields after accept so any late sampling is visible.
  task automatic scramble;
    pix_valid  = 1'b0;
    pix_x      = 6'($urandom);
    pix_y      = 6'($urandom);
    tile_base  = 10'($urandom);
    color_8bpp = 1'($urandom);
    pal_bank   = 4'($urandom);
    map_1d     = 1'($urandom);
    hsize      = 7'($urandom);
    pix_col    = 8'($urandom);
  endtask

  task automatic applyStimulus(input vec_t v, input int gd, input int rd);
    check("ready_pre", 32'(pix_ready), 1);
    drive_pixel(v);
    @(negedge clock);
    scramble();
    check("req", 32'(vram_req), 1);
    check("addr", 32'(vram_addr), 32'(v.exp_addr));
    for (int i = 0; i < gd; i++) begin
      vram_rvalid = 1'($urandom);
      vram_rdata  = 16'($urandom);
      @(negedge clock);
      check("req_hold", 32'(vram_req), 1);
      check("addr_hold", 32'(vram_addr), 32'(v.exp_addr));
    end
    vram_rvalid = 1'b0;
    vram_gnt    = 1'b1;
    @(negedge clock);
    vram_gnt = 1'b0;
    check("req_drop", 32'(vram_req), 0);
    for (int i = 0; i < rd; i++) begin
      @(negedge clock);
      check("we_idle_wait", 32'(lb_we), 0);
    end
    vram_rvalid = 1'b1;
    vram_rdata  = v.rdata;
    @(negedge clock);
    vram_rvalid = 1'b0;
    vram_rdata  = 16'($urandom);
    checkOutput(v);
  endtask

  task automatic checkOutput(input vec_t v);
    check("we", 32'(lb_we), 32'(v.exp_we));
    if (v.exp_we) begin
      check("lb_addr", 32'(lb_addr), 32'(v.col));
      check("lb_data", 32'(lb_data), 32'(v.exp_data));
    end
    check("ready_in_write", 32'(pix_ready), 0);
    @(negedge clock);
    check("we_pulse", 32'(lb_we), 0);
    check("ready_post", 32'(pix_ready), 1);
  endtask

  initial begin
    vec_t v;
    // x, y, base, c8, bank, m1d, hs, col, rdata, exp_addr, exp_we, exp_data
    vecs[0] = '{6'd9,  6'd10, 10'd4,    1'b0, 4'd3,  1'b1, 7'd16, 8'd50,  16'h00A5, 14'h0074, 1'b1, 8'h3A};
    vecs[1] = '{6'd17, 6'd9,  10'd10,   1'b1, 4'd0,  1'b0, 7'd64, 8'd7,   16'h7F00, 14'h02E4, 1'b1, 8'h7F};
    vecs[2] = '{6'd9,  6'd10, 10'd4,    1'b0, 4'd3,  1'b1, 7'd16, 8'd51,  16'hFF0F, 14'h0074, 1'b0, 8'h00};
    vecs[3] = '{6'd17, 6'd9,  10'd10,   1'b1, 4'd0,  1'b0, 7'd64, 8'd8,   16'h00FF, 14'h02E4, 1'b0, 8'h00};
    vecs[4] = '{6'd8,  6'd0,  10'd1023, 1'b0, 4'd5,  1'b1, 7'd16, 8'd200, 16'h0003, 14'h0000, 1'b1, 8'h53};
    vecs[5] = '{6'd63, 6'd63, 10'd0,    1'b1, 4'd0,  1'b1, 7'd64, 8'd255, 16'h1234, 14'h07FF, 1'b1, 8'h12};
    vecs[6] = '{6'd5,  6'd3,  10'd100,  1'b0, 4'hF,  1'b0, 7'd32, 8'd1,   16'h00C0, 14'h0647, 1'b1, 8'hFC};

    reset = 1'b1; pix_valid = 1'b0; pix_transp = 1'b0; line_abort = 1'b0;
    vram_gnt = 1'b0; vram_rvalid = 1'b0; vram_rdata = 16'h0;
    scramble();
    #3;
    check("rst_req", 32'(vram_req), 0);
    check("rst_addr", 32'(vram_addr), 0);
    check("rst_we", 32'(lb_we), 0);
    check("rst_lbaddr", 32'(lb_addr), 0);
    check("rst_lbdata", 32'(lb_data), 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_ready", 32'(pix_ready), 1);

    $display("[TB] directed vectors");
    foreach (vecs[i]) applyStimulus(vecs[i], 0, 0);

    $display("[TB] transparent back-to-back");
    for (int i = 0; i < 4; i++) begin
      pix_valid = 1'b1; pix_transp = 1'b1;
      pix_x = 6'($urandom); pix_y = 6'($urandom);
      @(negedge clock);
      check("transp_ready", 32'(pix_ready), 1);
      check("transp_req", 32'(vram_req), 0);
      check("transp_we", 32'(lb_we), 0);
    end
    pix_valid = 1'b0; pix_transp = 1'b0;
    @(negedge clock);

    $display("[TB] grant stall then abort in WAIT");
    drive_pixel(vecs[0]);
    @(negedge clock);
    scramble();
    for (int i = 0; i < 5; i++) begin
      check("stall_req", 32'(vram_req), 1);
      check("stall_addr", 32'(vram_addr), 32'h74);
      @(negedge clock);
    end
    vram_gnt = 1'b1;
    @(negedge clock);
    vram_gnt = 1'b0;
    line_abort = 1'b1;
    @(negedge clock);
    line_abort = 1'b0;
    pix_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check("drain_ready", 32'(pix_ready), 0);
      check("drain_req", 32'(vram_req), 0);
      check("drain_we", 32'(lb_we), 0);
      @(negedge clock);
    end
    pix_valid = 1'b0;
    vram_rvalid = 1'b1; vram_rdata = 16'h00A5;
    @(negedge clock);
    vram_rvalid = 1'b0;
    check("drain_nowrite", 32'(lb_we), 0);
    check("drain_idle", 32'(pix_ready), 1);
    check("drain_noreq", 32'(vram_req), 0);
    @(negedge clock);
    check("drain_nowrite2", 32'(lb_we), 0);

    $display("[TB] abort in REQ");
    drive_pixel(vecs[1]);
    @(negedge clock);
    scramble();
    check("abreq_req", 32'(vram_req), 1);
    line_abort = 1'b1;
    pix_valid = 1'b1;
    @(negedge clock);
    check("abreq_drop", 32'(vram_req), 0);
    check("abreq_ready", 32'(pix_ready), 1);
    @(negedge clock);
    check("abreq_blocked", 32'(vram_req), 0);
    line_abort = 1'b0; pix_valid = 1'b0;
    @(negedge clock);

    $display("[TB] async reset in REQ");
    drive_pixel(vecs[4]);
    pal_bank = 4'd5;
    @(negedge clock);
    scramble();
    check("rstreq_req", 32'(vram_req), 1);
    #1 reset = 1'b1;
    #1;
    check("rstreq_async", 32'(vram_req), 0);
    check("rstreq_ready", 32'(pix_ready), 1);
    @(negedge clock);
    reset = 1'b0;
    vram_rvalid = 1'b1; vram_rdata = 16'hFFFF;
    @(negedge clock);
    vram_rvalid = 1'b0;
    check("rstreq_late_rv", 32'(lb_we), 0);
    check("rstreq_idle", 32'(pix_ready), 1);

    $display("[TB] randomized pixels");
    for (int i = 0; i < 60; i++) begin
      v.x     = 6'($urandom);
      v.y     = 6'($urandom);
      v.base  = 10'($urandom);
      v.c8    = 1'($urandom);
      v.bank  = 4'($urandom);
      v.m1d   = 1'($urandom);
      v.hs    = 7'(8 << $urandom_range(0, 3));
      v.col   = 8'($urandom);
      v.rdata = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      v = model_vec(v);
      applyStimulus(v, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
